// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared constants, window slot mapping and FSM encoding for the 3x3 window generator
package conv_pkg;

    localparam int DATA_WIDTH  = 32;
    localparam int KERNEL_DIM  = 3;
    localparam int KERNEL_SIZE = 9;

    typedef enum logic [1:0] {
        FILL = 2'd0,
        RUN  = 2'd1
    } state_t;

    function automatic int unsigned slot(input int unsigned r, input int unsigned c);
        return r * KERNEL_DIM + c;
    endfunction

endpackage

// File: rtl/conv_window_gen_if.sv
// rtl/conv_window_gen_if.sv - pixel stream in, 3x3 window stream out
interface conv_window_gen_if #(
    parameter int DataWidth  = 32,
    parameter int KernelSize = 9
);
    logic [DataWidth-1:0]            pixel_in;
    logic                            pixel_valid;
    logic [KernelSize*DataWidth-1:0] window_out;
    logic                            window_valid;
    logic                            frame_done;
    logic                            busy;

    modport master (
        output pixel_in, pixel_valid,
        input  window_out, window_valid, frame_done, busy
    );

    modport slave (
        input  pixel_in, pixel_valid,
        output window_out, window_valid, frame_done, busy
    );
endinterface

// File: rtl/conv_line_buffer.sv
// rtl/conv_line_buffer.sv - enabled delay line, Depth accepted samples deep
module conv_line_buffer #(
    parameter int DataWidth = 32,
    parameter int Depth     = 28
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 en,
    input  logic [DataWidth-1:0] din,
    output logic [DataWidth-1:0] dout
);
    logic [DataWidth-1:0] taps [Depth];

    always_ff @(posedge Clk) begin
        if (Rst) begin
            for (int i = 0; i < Depth; i++) taps[i] <= '0;
        end else if (en) begin
            taps[0] <= din;
            for (int i = 1; i < Depth; i++) taps[i] <= taps[i-1];
        end
    end

    assign dout = taps[Depth-1];
endmodule

// File: rtl/conv_window_gen.sv
// rtl/conv_window_gen.sv - streaming 3x3 valid-mode window generator feeding the convolution block
module conv_window_gen
    import conv_pkg::*;
#(
    parameter int DataWidth  = DATA_WIDTH,
    parameter int ImgWidth   = 28,
    parameter int ImgHeight  = 28,
    parameter int KernelSize = KERNEL_SIZE
) (
    input logic             Clk,
    input logic             Rst,
    conv_window_gen_if.slave io
);
    if (KernelSize != KERNEL_SIZE) begin : g_bad_kernel
        $error("conv_window_gen supports only a 3x3 kernel");
    end

    localparam int CW = $clog2(ImgWidth);
    localparam int RW = $clog2(ImgHeight);
    localparam logic [CW-1:0] COL_LAST = CW'(ImgWidth - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(ImgHeight - 1);
    localparam logic [CW-1:0] COL_TWO  = CW'(2);
    localparam logic [RW-1:0] ROW_TWO  = RW'(2);

    logic                 accept;
    logic [CW-1:0]        col_cnt, col_next;
    logic [RW-1:0]        row_cnt, row_next;
    state_t               state_q, state_d;
    logic                 emit, last;
    logic [DataWidth-1:0] lb1_out, lb2_out;
    logic [DataWidth-1:0] new_col [KERNEL_DIM];
    logic [DataWidth-1:0] col_q [KERNEL_DIM][KERNEL_DIM];
    logic [KernelSize*DataWidth-1:0] win_next;

    assign accept = io.pixel_valid;

    conv_line_buffer #(.DataWidth(DataWidth), .Depth(ImgWidth)) u_lb1 (
        .Clk(Clk), .Rst(Rst), .en(accept), .din(io.pixel_in), .dout(lb1_out)
    );

    conv_line_buffer #(.DataWidth(DataWidth), .Depth(ImgWidth)) u_lb2 (
        .Clk(Clk), .Rst(Rst), .en(accept), .din(lb1_out), .dout(lb2_out)
    );

    always_comb begin
        col_next = col_cnt;
        row_next = row_cnt;
        if (accept) begin
            if (col_cnt == COL_LAST) begin
                col_next = '0;
                row_next = (row_cnt == ROW_LAST) ? '0 : row_cnt + 1'b1;
            end else begin
                col_next = col_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) state_q <= FILL;
        else     state_q <= state_d;
    end

    // RUN covers rows 2.. of a frame; the frame wrap drops back to FILL
    always_comb begin
        state_d = state_q;
        emit    = 1'b0;
        last    = 1'b0;
        case (state_q)
            FILL: begin
                if (accept && row_next >= ROW_TWO) state_d = RUN;
            end
            RUN: begin
                emit = accept && (col_cnt >= COL_TWO);
                last = emit && (row_cnt == ROW_LAST) && (col_cnt == COL_LAST);
                if (accept && row_next < ROW_TWO) state_d = FILL;
            end
            default: state_d = FILL;
        endcase
    end

    always_comb begin
        new_col[0] = lb2_out;
        new_col[1] = lb1_out;
        new_col[2] = io.pixel_in;
    end

    // Window is built from the two surviving columns plus the column entering this edge
    always_comb begin
        win_next = '0;
        for (int r = 0; r < KERNEL_DIM; r++) begin
            for (int c = 0; c < KERNEL_DIM; c++) begin
                case (c)
                    0:       win_next[slot(r, c)*DataWidth +: DataWidth] = col_q[1][r];
                    1:       win_next[slot(r, c)*DataWidth +: DataWidth] = col_q[2][r];
                    default: win_next[slot(r, c)*DataWidth +: DataWidth] = new_col[r];
                endcase
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            col_cnt         <= '0;
            row_cnt         <= '0;
            io.window_out   <= '0;
            io.window_valid <= 1'b0;
            io.frame_done   <= 1'b0;
            io.busy         <= 1'b0;
            for (int c = 0; c < KERNEL_DIM; c++)
                for (int r = 0; r < KERNEL_DIM; r++)
                    col_q[c][r] <= '0;
        end else begin
            col_cnt         <= col_next;
            row_cnt         <= row_next;
            io.window_valid <= emit;
            io.frame_done   <= last;
            if (emit) io.window_out <= win_next;
            if (accept) begin
                col_q[0] <= col_q[1];
                col_q[1] <= col_q[2];
                for (int r = 0; r < KERNEL_DIM; r++) col_q[2][r] <= new_col[r];
            end
            if (accept)             io.busy <= 1'b1;
            else if (io.frame_done) io.busy <= 1'b0;
        end
    end
endmodule
